canvas_input_conditioner: RTL and testbench
===========================================

Name: canvas_input_conditioner

Overview:
- Front-end stage between the TT pin wrapper and the canvas core.
- Takes the four already-inverted pushbutton levels (active-high) plus the RGB/brush switch levels.
- Synchronises all inputs; debounces the buttons; emits one-cycle cursor step pulses with optional hold-to-repeat.
- The canvas core consumes step pulses instead of raw button levels, so one press moves the cursor exactly once.

Parameters:
- DEBOUNCE_CYCLES, 50000, cycles a synced button must differ from its stable state before the stable state flips (>=2).
- REPEAT_DELAY, 25000000, cycles a button must be held after its press pulse before the first repeat pulse (>=2; used only with repeat).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=2; used only with repeat).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_raw  in  4  raw button levels, active-high; [3]=up, [2]=down, [1]=right, [0]=left
- rgb_raw  in  3  raw colour switches {R,G,B}
- brush_raw  in  1  raw brush/eraser switch
- btn_held  out  4  debounced stable button levels
- step  out  4  one-cycle move pulses, same bit order as btn_raw
- rgb_sync  out  3  synchronised colour switches
- brush_sync  out  1  synchronised brush switch
- any_held  out  1  OR of btn_held

Behaviour:
- Reset (rst=1 at a clk edge): all synchroniser flops, btn_held, step, rgb_sync, brush_sync, any_held, debounce counters and the repeat FSM go to 0/IDLE on that edge. Reset asserted mid-count or mid-repeat discards the operation; no pulse is emitted on or after the reset edge.
- Synchronisers: 2-flop chain on every input bit. rgb_sync and brush_sync are the second flop; latency 2 cycles; no debounce.
- Debounce, per button i, independent:
  - cnt[i] width = $clog2(DEBOUNCE_CYCLES).
  - If synced == btn_held[i]: cnt clears to 0.
  - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1 and synced still differs, btn_held[i] toggles and cnt clears.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count.
  - Raw edge to btn_held change = 2 + DEBOUNCE_CYCLES cycles.
- Press pulse: step[i] is registered and high for exactly one cycle, in the cycle after btn_held[i] rises. Release produces no pulse.
- Simultaneous presses: independent; several step bits may be high in the same cycle. Opposite directions are not masked here; the core resolves them.
- any_held is registered from btn_held and lags it by one cycle.
- With repeat compiled in, step is OR of the press pulse and the repeat pulse per bit; never more than one cycle high per event.
- Reset-value check: step=0 and btn_held=0 for at least 2+DEBOUNCE_CYCLES cycles after reset release, whatever the inputs.

Optional Feature:
- Macro: CANVAS_BTN_REPEAT_EN.
- Defined: shared repeat FSM with one timer, width $clog2(REPEAT_DELAY).
  - IDLE: timer=0. On any press pulse, go to DELAY.
  - DELAY: timer increments. If btn_held==0, go to IDLE. Any new press pulse restarts timer at 0. When timer == REPEAT_DELAY-1, pulse step for every bit of btn_held, clear timer, go to REPEAT.
  - REPEAT: timer increments. At REPEAT_PERIOD-1, pulse all held bits and clear timer. If btn_held==0, go to IDLE. A new press pulse goes to DELAY with timer 0.
  - Release of one button while others stay held keeps the state; only held bits pulse.
- Undefined: no FSM or timer is synthesised; step carries press pulses only. REPEAT_* parameters are accepted and ignored.

Decomposition:
- Shared package canvas_pkg holds:
  - BTN_UP=3, BTN_DOWN=2, BTN_RIGHT=1, BTN_LEFT=0 index constants.
  - NUM_BTN=4.
  - Repeat FSM state enum: IDLE, DELAY, REPEAT.
- One natural sub-module: canvas_debounce, single-bit 2-flop sync + counter + stable reg, instantiated 4 times. The repeat FSM stays in the parent.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset: drive btn_raw=4'hF during rst, release -> step=0 and btn_held=0 for 6 cycles; btn_held=4'hF on cycle 6; step=4'hF exactly one cycle on cycle 7.
- Bounce: btn_raw[0] toggled 1,0,1,0 every 2 cycles, then held 1 -> exactly one step[0] pulse, 7 cycles after the final stable rise; none during bounce.
- Release: hold btn_raw[2] until btn_held[2]=1, then release and bounce the release -> btn_held[2] falls once and no step pulse.
- Switch sync: rgb_raw 3'b000->3'b101 -> rgb_sync=3'b101 exactly 2 cycles later; brush_raw likewise.
- Repeat (macro defined): hold up -> press pulse, then step[3] pulses 20 cycles later, then every 8 cycles. Release -> no further pulses. Pressing left during REPEAT -> left press pulse, then next repeat 20 cycles later on {up,left}.
- Reset mid-repeat: assert rst during REPEAT -> step=0, FSM IDLE next edge. With the macro undefined, holding up for 100 cycles -> exactly one pulse.

Source files
------------

// File: rtl/canvas_pkg.sv
// -----------------------------------------------------------------------------
// canvas_pkg
// Shared definitions for the canvas front-end.
//   - Button index constants (bit positions inside every 4-bit button bus)
//   - Repeat FSM state enumeration
//   - Small constant helper used when sizing counters
// No ports; imported by canvas_debounce and canvas_input_conditioner.
// -----------------------------------------------------------------------------
package canvas_pkg;

    localparam int NUM_BTN   = 4;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_LEFT  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // Larger of two integers, used to size a timer shared by two limits.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/canvas_debounce.sv
// -----------------------------------------------------------------------------
// canvas_debounce
// Single-bit conditioner for one pushbutton: 2-flop synchroniser, a run
// counter and the stable (debounced) level register.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   raw_in    in   raw button level, active-high
//   held_out  out  debounced stable level
// Parameter:
//   DEBOUNCE_CYCLES  consecutive synced cycles of disagreement needed before
//                    the stable level flips (>= 2)
// -----------------------------------------------------------------------------
module canvas_debounce
    import canvas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic held_out
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             held_q,  held_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state logic. The counter only runs while the synchronised level
    // disagrees with the stable level; any agreeing cycle (a glitch back)
    // throws the partial count away. The flip happens on the cycle the
    // counter would otherwise reach DEBOUNCE_CYCLES, so the stable level
    // changes exactly DEBOUNCE_CYCLES disagreeing cycles after they begin.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        held_d  = held_q;
        cnt_d   = '0;
        if (sync2_q != held_q) begin
            if (cnt_q == CNT_MAX) begin
                held_d = ~held_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    assign held_out = held_q;

endmodule

// File: rtl/canvas_input_conditioner.sv
// -----------------------------------------------------------------------------
// canvas_input_conditioner
// Front end between the pin wrapper and the canvas core. Synchronises the
// switches, debounces the four buttons and turns each press into a single
// one-cycle step pulse so one press moves the cursor exactly once.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   btn_raw     in   [3]=up [2]=down [1]=right [0]=left, active-high
//   rgb_raw     in   colour switches {R,G,B}
//   brush_raw   in   brush/eraser switch
//   btn_held    out  debounced stable button levels
//   step        out  one-cycle move pulses, same bit order as btn_raw
//   rgb_sync    out  synchronised colour switches (2-cycle latency)
//   brush_sync  out  synchronised brush switch (2-cycle latency)
//   any_held    out  OR of btn_held, one cycle behind it
// Build option:
//   CANVAS_BTN_REPEAT_EN  when defined, adds a shared hold-to-repeat FSM that
//                         re-pulses every held button after REPEAT_DELAY
//                         cycles and then every REPEAT_PERIOD cycles. When
//                         undefined, the REPEAT_* parameters are ignored.
// -----------------------------------------------------------------------------
module canvas_input_conditioner
    import canvas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [2:0]         rgb_raw,
    input  logic               brush_raw,
    output logic [NUM_BTN-1:0] btn_held,
    output logic [NUM_BTN-1:0] step,
    output logic [2:0]         rgb_sync,
    output logic               brush_sync,
    output logic               any_held
);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("canvas_input_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("canvas_input_conditioner: REPEAT_DELAY/REPEAT_PERIOD must be >= 2");
    end
    if (BTN_UP != 3 || BTN_DOWN != 2 || BTN_RIGHT != 1 || BTN_LEFT != 0) begin : g_bad_order
        $error("canvas_input_conditioner: button index constants out of order");
    end

    logic [NUM_BTN-1:0] held;
    logic [NUM_BTN-1:0] press_pulse;

    logic [2:0]         rgb_s1_q,    rgb_s1_d;
    logic [2:0]         rgb_s2_q,    rgb_s2_d;
    logic               brush_s1_q,  brush_s1_d;
    logic               brush_s2_q,  brush_s2_d;
    logic [NUM_BTN-1:0] held_prev_q, held_prev_d;
    logic [NUM_BTN-1:0] step_q,      step_d;
    logic               any_held_q,  any_held_d;

    // One independent debouncer per button; simultaneous presses are kept
    // apart and opposite directions are left for the core to arbitrate.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        canvas_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .raw_in   (btn_raw[i]),
            .held_out (held[i])
        );
    end

    // A press is the first cycle a debounced level is seen high; releases
    // are deliberately ignored.
    assign press_pulse = held & ~held_prev_q;

`ifdef CANVAS_BTN_REPEAT_EN

    // One timer serves both the initial delay and the repeat period, so it
    // is sized for whichever limit is larger.
    localparam int               TMR_W       = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    rep_state_e         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [NUM_BTN-1:0] rep_pulse;

    // Repeat FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Repeat FSM next-state logic. Priority in the active states is: all
    // buttons released (abandon), then a fresh press (restart the long
    // delay so the new button gets a full hold time), then the timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (|press_pulse) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (held == '0) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (|press_pulse) begin
                    timer_d = '0;
                end else if (timer_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (held == '0) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (|press_pulse) begin
                    state_d = DELAY;
                    timer_d = '0;
                end else if (timer_q == PERIOD_LAST) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Repeat FSM outputs: on expiry, re-pulse whatever is held right now,
    // so a button released mid-repeat simply drops out of the pattern.
    always_comb begin
        rep_pulse = '0;
        case (state_q)
            DELAY: begin
                if (held != '0 && press_pulse == '0 && timer_q == DELAY_LAST) begin
                    rep_pulse = held;
                end
            end
            REPEAT: begin
                if (held != '0 && press_pulse == '0 && timer_q == PERIOD_LAST) begin
                    rep_pulse = held;
                end
            end
            default: begin
                rep_pulse = '0;
            end
        endcase
    end

    // Step pulses combine fresh presses with repeat expiries.
    always_comb begin
        step_d = press_pulse | rep_pulse;
    end

`else

    // Without repeat, the cursor moves only on fresh presses.
    always_comb begin
        step_d = press_pulse;
    end

`endif

    // Switch synchronisers and the per-button output staging.
    always_comb begin
        rgb_s1_d    = rgb_raw;
        rgb_s2_d    = rgb_s1_q;
        brush_s1_d  = brush_raw;
        brush_s2_d  = brush_s1_q;
        held_prev_d = held;
        any_held_d  = |held;
    end

    // Output registers; reset kills any pulse that would have fired.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s1_q    <= '0;
            rgb_s2_q    <= '0;
            brush_s1_q  <= 1'b0;
            brush_s2_q  <= 1'b0;
            held_prev_q <= '0;
            step_q      <= '0;
            any_held_q  <= 1'b0;
        end else begin
            rgb_s1_q    <= rgb_s1_d;
            rgb_s2_q    <= rgb_s2_d;
            brush_s1_q  <= brush_s1_d;
            brush_s2_q  <= brush_s2_d;
            held_prev_q <= held_prev_d;
            step_q      <= step_d;
            any_held_q  <= any_held_d;
        end
    end

    assign btn_held   = held;
    assign step       = step_q;
    assign rgb_sync   = rgb_s2_q;
    assign brush_sync = brush_s2_q;
    assign any_held   = any_held_q;

endmodule

// File: tb/tb_canvas_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_canvas_input_conditioner
// Self-checking bench for canvas_input_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. A behavioural model tracks, per clock
// edge, what every output must be; directed steps add explicit timing checks
// and a randomized phase exercises overlapping presses and resets.
// -----------------------------------------------------------------------------
module tb_canvas_input_conditioner;

    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic [2:0] rgb_raw;
    logic       brush_raw;
    logic [3:0] btn_held;
    logic [3:0] step;
    logic [2:0] rgb_sync;
    logic       brush_sync;
    logic       any_held;

    canvas_input_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .rgb_raw    (rgb_raw),
        .brush_raw  (brush_raw),
        .btn_held   (btn_held),
        .step       (step),
        .rgb_sync   (rgb_sync),
        .brush_sync (brush_sync),
        .any_held   (any_held)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus currently being applied.
    logic       cur_rst;
    logic [3:0] cur_btn;
    logic [2:0] cur_rgb;
    logic       cur_brush;

    // Check bookkeeping.
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Observed pulse/fall counters for the directed checks.
    int         step_cnt [4];
    int         fall_cnt [4];
    logic [3:0] last_held_obs;

    // Reference model state: raw-input delay lines (2-cycle synchroniser
    // latency), disagreement run lengths, stable levels and repeat timing
    // expressed as absolute cycle numbers.
    logic [3:0] m_bh1, m_bh2;
    logic [2:0] m_rgb_h1;
    logic       m_brush_h1;
    logic [3:0] m_held, m_held_prev;
    int         m_run [4];
    int         m_cyc;
    bit         m_active;
    int         m_anchor, m_wait;

    logic [3:0] exp_step, exp_held;
    logic [2:0] exp_rgb;
    logic       exp_brush, exp_any;

    // Advance the model by one clock edge using the stimulus at that edge.
    task automatic modelEdge();
        logic [3:0] held_old;
        logic [3:0] press;
        logic [3:0] rep;
        held_old = m_held;
        press    = '0;
        rep      = '0;
        if (cur_rst) begin
            m_bh1 = '0; m_bh2 = '0; m_rgb_h1 = '0; m_brush_h1 = 1'b0;
            m_held = '0; m_held_prev = '0; m_active = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            exp_step = '0; exp_rgb = '0; exp_brush = 1'b0; exp_any = 1'b0;
        end else begin
            press = held_old & ~m_held_prev;
`ifdef CANVAS_BTN_REPEAT_EN
            if (held_old == 4'b0) begin
                m_active = 0;
            end else if (press != 4'b0) begin
                m_active = 1; m_anchor = m_cyc; m_wait = RD;
            end else if (m_active && (m_cyc - m_anchor) == m_wait) begin
                rep = held_old; m_anchor = m_cyc; m_wait = RP;
            end
`endif
            exp_step = press | rep;
            exp_any  = |held_old;
            for (int i = 0; i < 4; i++) begin
                if (m_bh2[i] != held_old[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_held[i] = ~held_old[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_held_prev = held_old;
            exp_rgb    = m_rgb_h1;   m_rgb_h1   = cur_rgb;
            exp_brush  = m_brush_h1; m_brush_h1 = cur_brush;
            m_bh2 = m_bh1; m_bh1 = cur_btn;
        end
        exp_held = m_held;
        m_cyc++;
    endtask

    // One comparison: counts it, and reports observed/expected on mismatch.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model after an edge.
    task automatic checkOutput();
        checkVal("step",       32'(step),       32'(exp_step));
        checkVal("btn_held",   32'(btn_held),   32'(exp_held));
        checkVal("any_held",   32'(any_held),   32'(exp_any));
        checkVal("rgb_sync",   32'(rgb_sync),   32'(exp_rgb));
        checkVal("brush_sync", 32'(brush_sync), 32'(exp_brush));
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 4; i++) begin
            step_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    endtask

    // Apply the current stimulus for n cycles, checking after each edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            rst       = cur_rst;
            btn_raw   = cur_btn;
            rgb_raw   = cur_rgb;
            brush_raw = cur_brush;
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            checkOutput();
            for (int i = 0; i < 4; i++) begin
                if (step[i] === 1'b1) step_cnt[i]++;
                if (last_held_obs[i] === 1'b1 && btn_held[i] === 1'b0) fall_cnt[i]++;
            end
            last_held_obs = btn_held;
        end
    endtask

    initial begin
        m_cyc = 0; m_active = 0; m_anchor = 0; m_wait = 0;
        m_held = '0; m_held_prev = '0; m_bh1 = '0; m_bh2 = '0;
        m_rgb_h1 = '0; m_brush_h1 = 1'b0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        last_held_obs = '0;
        clearCounts();

        // Reset with all buttons already pressed.
        $display("[TB] reset with buttons held");
        cur_rst = 1'b1; cur_btn = 4'hF; cur_rgb = 3'b000; cur_brush = 1'b0;
        applyStimulus(3);
        cur_rst = 1'b0;
        applyStimulus(5);
        checkVal("rst_held_c5", 32'(btn_held), 32'h0);
        checkVal("rst_step_c5", 32'(step), 32'h0);
        applyStimulus(1);
        checkVal("rst_held_c6", 32'(btn_held), 32'hF);
        applyStimulus(1);
        checkVal("rst_step_c7", 32'(step), 32'hF);
        applyStimulus(1);
        checkVal("rst_step_c8", 32'(step), 32'h0);
        cur_btn = 4'h0;
        applyStimulus(10);
        checkVal("rst_released", 32'(btn_held), 32'h0);

        // Bouncing press on left.
        $display("[TB] bounce on left");
        clearCounts();
        for (int k = 0; k < 4; k++) begin
            cur_btn = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            applyStimulus(2);
        end
        checkVal("bounce_quiet", 32'(step_cnt[0]), 32'd0);
        cur_btn = 4'b0001;
        applyStimulus(6);
        checkVal("bounce_pre", 32'(step), 32'h0);
        applyStimulus(1);
        checkVal("bounce_step7", 32'(step), 32'b0001);
        checkVal("bounce_once", 32'(step_cnt[0]), 32'd1);
        cur_btn = 4'b0000;
        applyStimulus(10);

        // Bounced release on down.
        $display("[TB] bounced release on down");
        cur_btn = 4'b0100;
        applyStimulus(6);
        checkVal("rel_held", 32'(btn_held), 32'b0100);
        applyStimulus(1);
        checkVal("rel_press", 32'(step), 32'b0100);
        clearCounts();
        cur_btn = 4'b0000; applyStimulus(1);
        cur_btn = 4'b0100; applyStimulus(1);
        cur_btn = 4'b0000; applyStimulus(12);
        checkVal("rel_no_step", 32'(step_cnt[2]), 32'd0);
        checkVal("rel_one_fall", 32'(fall_cnt[2]), 32'd1);
        checkVal("rel_low", 32'(btn_held), 32'h0);

        // Switch synchronisation latency.
        $display("[TB] switch sync");
        applyStimulus(3);
        cur_rgb = 3'b101; cur_brush = 1'b1;
        applyStimulus(1);
        checkVal("rgb_lat1", 32'(rgb_sync), 32'b000);
        checkVal("brush_lat1", 32'(brush_sync), 32'b0);
        applyStimulus(1);
        checkVal("rgb_lat2", 32'(rgb_sync), 32'b101);
        checkVal("brush_lat2", 32'(brush_sync), 32'b1);

`ifdef CANVAS_BTN_REPEAT_EN
        // Hold-to-repeat on up, then add left mid-repeat.
        $display("[TB] repeat on up");
        clearCounts();
        cur_btn = 4'b1000;
        applyStimulus(7);
        checkVal("rep_press", 32'(step), 32'b1000);
        applyStimulus(19);
        checkVal("rep_gap", 32'(step_cnt[3]), 32'd1);
        applyStimulus(1);
        checkVal("rep_first", 32'(step), 32'b1000);
        applyStimulus(7);
        checkVal("rep_between", 32'(step), 32'h0);
        applyStimulus(1);
        checkVal("rep_period", 32'(step), 32'b1000);
        cur_btn = 4'b1001;
        applyStimulus(6);
        checkVal("left_pre", 32'(step), 32'h0);
        applyStimulus(1);
        checkVal("left_press", 32'(step), 32'b0001);
        clearCounts();
        applyStimulus(19);
        checkVal("left_gap_up", 32'(step_cnt[3]), 32'd0);
        checkVal("left_gap_left", 32'(step_cnt[0]), 32'd0);
        applyStimulus(1);
        checkVal("rep_both", 32'(step), 32'b1001);
        applyStimulus(3);
        cur_rst = 1'b1;
        applyStimulus(1);
        checkVal("rst_mid_step", 32'(step), 32'h0);
        checkVal("rst_mid_held", 32'(btn_held), 32'h0);
        cur_rst = 1'b0; cur_btn = 4'b0000;
        clearCounts();
        applyStimulus(30);
        checkVal("rst_mid_quiet", 32'(step_cnt[3] + step_cnt[0]), 32'd0);
`else
        // Long hold without repeat gives a single move.
        $display("[TB] long hold, no repeat");
        clearCounts();
        cur_btn = 4'b1000;
        applyStimulus(100);
        checkVal("hold100_one", 32'(step_cnt[3]), 32'd1);
        cur_btn = 4'b0000;
        applyStimulus(10);
`endif

        // Randomized segments with occasional resets.
        $display("[TB] random phase");
        for (int seg = 0; seg < 60; seg++) begin
            cur_btn   = 4'($urandom);
            cur_rgb   = 3'($urandom);
            cur_brush = 1'($urandom);
            cur_rst   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) applyStimulus(int'($urandom_range(20, 45)));
            else                           applyStimulus(int'($urandom_range(1, 12)));
        end
        cur_rst = 1'b0;
        applyStimulus(5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
